ram_512x8: RTL and testbench



---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_parity_gen.sv | 20 ++
 rtl/ram_512x8.sv | 87 ++++++++
 tb/tb_ram_512x8.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the 512x8 byte store.
package ram_pkg;

  localparam int RAM_DEPTH  = 512;
  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef logic [7:0] ram_byte_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [RAM_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_parity_gen.sv
// Combinational even-parity generator (write side) and checker (read side).
import ram_pkg::*;

module ram_parity_gen #(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_par,
  output logic              wr_par,
  output logic              rd_err
);

  // Generate parity for incoming data and flag stored data/parity disagreement.
  always_comb begin
    wr_par = even_parity(wr_data);
    rd_err = even_parity(rd_data) ^ rd_par;
  end

endmodule

// File: rtl/ram_512x8.sv
// 512-entry byte RAM: clocked writes, combinational gated read, async clear.
// Optional per-byte even parity with RAM512X8_PARITY_EN.
import ram_pkg::*;

module ram_512x8 #(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
`ifdef RAM512X8_PARITY_EN
  output logic              ParityErr,
`endif
  output logic [DATA_W-1:0] DataOut
);

`ifdef RAM512X8_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;
  logic              wr_en_s;
  logic              rd_en_s;

  // Case equality keeps an X/Z on the controls from being taken as a write.
  assign wr_en_s   = (Enable === 1'b1) && (ReadWrite === RW_WRITE);
  assign rd_en_s   = (Enable === 1'b1) && (ReadWrite === RW_READ) && !reset;
  assign rd_word_s = mem_r[Address];

`ifdef RAM512X8_PARITY_EN
  logic wr_par_s;
  logic rd_err_s;

  ram_parity_gen #(.DATA_W(DATA_W)) u_parity (
    .wr_data (DataIn),
    .rd_data (rd_word_s[DATA_W-1:0]),
    .rd_par  (rd_word_s[DATA_W]),
    .wr_par  (wr_par_s),
    .rd_err  (rd_err_s)
  );

  assign wr_word_s = {wr_par_s, DataIn};

  // Parity error is only meaningful while a read is being performed.
  always_comb begin
    ParityErr = 1'b0;
    if (rd_en_s) begin
      ParityErr = rd_err_s;
    end else begin
      ParityErr = 1'b0;
    end
  end
`else
  assign wr_word_s = DataIn;
`endif

  // Storage: reset clears every location and overrides a same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[Address] <= wr_word_s;
    end
  end

  // Read data is driven only during a read; zero otherwise.
  always_comb begin
    DataOut = '0;
    if (rd_en_s) begin
      DataOut = rd_word_s[DATA_W-1:0];
    end else begin
      DataOut = '0;
    end
  end

endmodule

// File: tb/tb_ram_512x8.sv
// Directed scoreboard bench for ram_512x8; driver queues expectations,
// negedge monitor compares DataOut (and ParityErr when enabled).
module tb_ram_512x8;

  logic       clk;
  logic       reset;
  logic       Enable;
  logic       ReadWrite;
  logic [8:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
`ifdef RAM512X8_PARITY_EN
  logic       ParityErr;
`endif

  typedef struct {
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic done;

  ram_512x8 dut (
    .clk       (clk),
    .reset     (reset),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
`ifdef RAM512X8_PARITY_EN
    .ParityErr (ParityErr),
`endif
    .DataOut   (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle: inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic en, input logic rw,
                     input logic [8:0] addr, input logic [7:0] din,
                     input logic chk, input logic [7:0] exp_data, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    Enable    = en;
    ReadWrite = rw;
    Address   = addr;
    DataIn    = din;
    if (chk) begin
      e.data = exp_data;
      e.name = name;
      exp_q.push_back(e);
    end
  endtask

  // Driver: directed vectors with hand-computed expected read data.
  initial begin
    done      = 1'b0;
    reset     = 1'b1;
    Enable    = 1'b0;
    ReadWrite = 1'b1;
    Address   = 9'd0;
    DataIn    = 8'h00;
    cyc(1'b1, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'h00, "reset_out");
    cyc(1'b0, 1'b1, 1'b0, 9'd0,   8'hFF, 1'b1, 8'h00, "write_out_zero");
    cyc(1'b0, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'hFF, "rd_a0_ff");
    cyc(1'b0, 1'b1, 1'b0, 9'd100, 8'hA5, 1'b0, 8'h00, "");
    cyc(1'b0, 1'b1, 1'b1, 9'd100, 8'h00, 1'b1, 8'hA5, "rd_a100_a5");
    cyc(1'b0, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'hFF, "rd_a0_kept");
    cyc(1'b0, 1'b0, 1'b1, 9'd0,   8'h00, 1'b1, 8'h00, "idle_read");
    cyc(1'b0, 1'b0, 1'b0, 9'd0,   8'hAA, 1'b1, 8'h00, "idle_write");
    cyc(1'b0, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'hFF, "idle_no_write");
    cyc(1'b0, 1'b1, 1'b0, 9'd511, 8'h3C, 1'b0, 8'h00, "");
    cyc(1'b0, 1'b1, 1'b0, 9'd1,   8'hC3, 1'b0, 8'h00, "");
    cyc(1'b0, 1'b1, 1'b1, 9'd511, 8'h00, 1'b1, 8'h3C, "rd_a511");
    cyc(1'b0, 1'b1, 1'b1, 9'd1,   8'h00, 1'b1, 8'hC3, "rd_a1");
    cyc(1'b0, 1'b1, 1'b1, 9'd100, 8'h00, 1'b1, 8'hA5, "rd_a100_no_alias");
    cyc(1'b0, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'hFF, "rd_a0_before_rst");
    // Reset rises between edges; the negedge check sees no clock since.
    cyc(1'b1, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'h00, "rst_async_out");
    cyc(1'b1, 1'b1, 1'b0, 9'd5,   8'h55, 1'b1, 8'h00, "rst_during_write");
    cyc(1'b0, 1'b1, 1'b1, 9'd5,   8'h00, 1'b1, 8'h00, "rst_write_dropped");
    cyc(1'b0, 1'b1, 1'b1, 9'd0,   8'h00, 1'b1, 8'h00, "rst_clr_a0");
    cyc(1'b0, 1'b1, 1'b1, 9'd100, 8'h00, 1'b1, 8'h00, "rst_clr_a100");
    cyc(1'b0, 1'b1, 1'b1, 9'd511, 8'h00, 1'b1, 8'h00, "rst_clr_a511");
    cyc(1'b0, 1'b1, 1'b1, 9'd1,   8'h00, 1'b1, 8'h00, "rst_clr_a1");
    cyc(1'b0, 1'b1, 1'b0, 9'd7,   8'h81, 1'b0, 8'h00, "");
    cyc(1'b0, 1'b1, 1'b1, 9'd7,   8'h00, 1'b1, 8'h81, "wr_after_rst");
    cyc(1'b0, 1'b0, 1'b1, 9'd0,   8'h00, 1'b0, 8'h00, "");
    done = 1'b1;
  end

  // Monitor: pops one expectation per presented read/idle cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (DataOut !== e.data) begin
        errors = errors + 1;
        $display("FAIL %s: DataOut=%h expected %h", e.name, DataOut, e.data);
      end
`ifdef RAM512X8_PARITY_EN
      checks = checks + 1;
      if (ParityErr !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL %s_parity: ParityErr=%b expected 0", e.name, ParityErr);
      end
`endif
    end else if (done) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
  end

endmodule
